// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory bootloader.
// The CKSUM state exists only when IMEM_LOADER_CKSUM_EN is defined.
package imem_loader_pkg;

  `ifdef IMEM_LOADER_CKSUM_EN
  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    CKSUM,
    DONE
  } state_t;
  `else
  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    DONE
  } state_t;
  `endif

  localparam int         HDR_BYTES     = 6;
  localparam int         WORD_BYTES    = 4;
  localparam logic [7:0] DEFAULT_MAGIC = 8'hB0;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream receive handshake plus the IMEM write port of the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 30
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_din;
  logic              imem_we;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_addr, imem_din, imem_we
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_addr, imem_din, imem_we
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// MSB-first byte-to-word assembler; word is the completed value in the
// cycle word_full is high (the 4th byte is taken straight from byte_in).
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [23:0] shift_reg;
  logic [1:0]  cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else if (clear) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else if (load) begin
      shift_reg <= {shift_reg[15:0], byte_in};
      cnt_reg   <= cnt_reg + 2'd1;
    end
  end

  // Counter wraps to 0 on the 4th byte, so the next word starts aligned.
  assign word      = {shift_reg, byte_in};
  assign word_full = load && (cnt_reg == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Frame-based bootloader writing instruction words into IMEM while holding
// the CPU in reset. Define IMEM_LOADER_CKSUM_EN for the XOR checksum trailer.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [7:0] MAGIC  = DEFAULT_MAGIC,
  parameter int         ADDR_W = 30
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  localparam int HS_W = ADDR_W + 8;

  state_t            state_reg, state_next;
  logic [HS_W-1:0]   hdr_shift_reg;
  logic [2:0]        hdr_cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       cnt_reg;
  logic [ADDR_W-1:0] imem_addr_reg;
  logic [31:0]       imem_din_reg;

  logic              accept;
  logic              magic_hit;
  logic              hdr_last;
  logic [ADDR_W+15:0] hdr_word;
  logic              asm_load;
  logic              asm_clear;
  logic [31:0]       asm_word;
  logic              asm_full;

  assign accept    = bus.rx_valid && bus.rx_ready;
  assign magic_hit = accept && (state_reg == IDLE) && (bus.rx_data == MAGIC);
  assign hdr_last  = accept && (state_reg == HDR) && (hdr_cnt_reg == 3'(HDR_BYTES - 1));
  // Upper address bits beyond ADDR_W have already been shifted out.
  assign hdr_word  = {hdr_shift_reg, bus.rx_data};
  assign asm_clear = magic_hit;

  `ifdef IMEM_LOADER_CKSUM_EN
  assign asm_load = accept && ((state_reg == DATA) || (state_reg == CKSUM));
  `else
  assign asm_load = accept && (state_reg == DATA);
  `endif

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .load      (asm_load),
    .clear     (asm_clear),
    .byte_in   (bus.rx_data),
    .word      (asm_word),
    .word_full (asm_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (magic_hit) state_next = HDR;
      HDR: begin
        if (hdr_last) begin
          if (hdr_word[15:0] != 16'd0) state_next = DATA;
          `ifdef IMEM_LOADER_CKSUM_EN
          else                         state_next = CKSUM;
          `else
          else                         state_next = DONE;
          `endif
        end
      end
      DATA:  if (asm_full) state_next = WRITE;
      WRITE: begin
        if (cnt_reg != 16'd1) state_next = DATA;
        `ifdef IMEM_LOADER_CKSUM_EN
        else                  state_next = CKSUM;
        `else
        else                  state_next = DONE;
        `endif
      end
      `ifdef IMEM_LOADER_CKSUM_EN
      CKSUM: if (asm_full) state_next = DONE;
      `endif
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_shift_reg <= '0;
      hdr_cnt_reg   <= '0;
      addr_reg      <= '0;
      cnt_reg       <= '0;
      imem_addr_reg <= '0;
      imem_din_reg  <= '0;
    end else begin
      if (magic_hit) hdr_cnt_reg <= '0;
      if (accept && (state_reg == HDR)) begin
        hdr_shift_reg <= HS_W'(hdr_word);
        hdr_cnt_reg   <= hdr_last ? 3'd0 : hdr_cnt_reg + 3'd1;
      end
      if (hdr_last) begin
        addr_reg <= hdr_word[ADDR_W+15:16];
        cnt_reg  <= hdr_word[15:0];
      end
      // Output registers change only at the edge that enters WRITE.
      if ((state_reg == DATA) && asm_full) begin
        imem_addr_reg <= addr_reg;
        imem_din_reg  <= asm_word;
      end
      if (state_reg == WRITE) begin
        addr_reg <= addr_reg + 1'b1;
        cnt_reg  <= cnt_reg - 16'd1;
      end
    end
  end

  `ifdef IMEM_LOADER_CKSUM_EN
  logic [31:0] acc_reg;
  logic        err_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      if (magic_hit) begin
        acc_reg <= '0;
        err_reg <= 1'b0;
      end
      if (state_reg == WRITE) acc_reg <= acc_reg ^ imem_din_reg;
      if ((state_reg == CKSUM) && asm_full && (asm_word != acc_reg)) err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
  `else
  assign err = 1'b0;
  `endif

  assign bus.rx_ready  = (state_reg != WRITE) && (state_reg != DONE);
  assign bus.imem_we   = (state_reg == WRITE);
  assign bus.imem_addr = imem_addr_reg;
  assign bus.imem_din  = imem_din_reg;
  assign cpu_hold      = (state_reg != IDLE);
  assign done          = (state_reg == DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame table plus hand-timed sequences for
// write/done latency, sticky err, and reset in the middle of a frame.
module tb_imem_loader;

  localparam int ADDR_W = 30;
  `ifdef IMEM_LOADER_CKSUM_EN
  localparam bit CK = 1'b1;
  `else
  localparam bit CK = 1'b0;
  `endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cpu_hold, done, err;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.MAGIC(8'hB0), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [ADDR_W-1:0] wa[$];
  logic [31:0]       wd[$];

  always @(negedge clk) begin
    if (bus.imem_we) begin
      wa.push_back(bus.imem_addr);
      wd.push_back(bus.imem_din);
      $display("write addr=%h data=%h", bus.imem_addr, bus.imem_din);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Returns 1 time unit after the edge that accepted the byte.
  task automatic send_byte(input logic [7:0] b, input int gap = 0);
    int guard;
    guard = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.rx_ready) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout actual=0 required=1");
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap = 0);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
  endtask

  task automatic send_hdr(input logic [31:0] a, input logic [15:0] n, input int gap = 0);
    send_byte(8'hB0, gap);
    send_word(a, gap);
    send_byte(n[15:8], gap);
    send_byte(n[7:0], gap);
  endtask

  task automatic wait_done(input int target);
    int guard;
    guard = 0;
    while (done_cnt < target && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    chk("done_pulses", 64'(done_cnt), 64'(target));
  endtask

  typedef struct {
    bit          garbage;
    int          gap;
    logic [31:0] addr;
    logic [15:0] n;
    logic [31:0] w0, w1;
    logic [31:0] ck;
    logic [29:0] ea0, ea1;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int d0;
    vecs[0] = '{1'b1, 0, 32'h0000_0010, 16'd2, 32'h401A_6800, 32'h401B_6000, 32'h0001_0800, 30'h10, 30'h11, 1'b0};
    vecs[1] = '{1'b0, 0, 32'h3FFF_FFFF, 16'd2, 32'h1234_5678, 32'h0F0F_0F0F, 32'h1D3B_5977, 30'h3FFF_FFFF, 30'h0, 1'b0};
    vecs[2] = '{1'b0, 0, 32'h0000_0000, 16'd0, 32'h0, 32'h0, 32'h0, 30'h0, 30'h0, 1'b0};
    vecs[3] = '{1'b0, 2, 32'hC000_0005, 16'd1, 32'hB0B0_B0B0, 32'h0, 32'hB0B0_B0B0, 30'h5, 30'h0, 1'b0};
    vecs[4] = '{1'b0, 0, 32'h0000_0100, 16'd2, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0, 30'h100, 30'h101, CK};

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    #12;
    chk("rst_rx_ready", 64'(bus.rx_ready), 64'd1);
    chk("rst_we", 64'(bus.imem_we), 64'd0);
    chk("rst_hold", 64'(cpu_hold), 64'd0);
    chk("rst_addr", 64'(bus.imem_addr), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic frame with cycle-exact latency checks.
    $display("frame basic addr=10 n=2");
    send_byte(8'hB0);
    chk("hold_after_magic", 64'(cpu_hold), 64'd1);
    send_word(32'h0000_0010);
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(32'h401A_6800);
    chk("w0_we", 64'(bus.imem_we), 64'd1);
    chk("w0_ready", 64'(bus.rx_ready), 64'd0);
    chk("w0_addr", 64'(bus.imem_addr), 64'h10);
    chk("w0_din", 64'(bus.imem_din), 64'h401A_6800);
    send_word(32'h401B_6000);
    chk("w1_addr", 64'(bus.imem_addr), 64'h11);
    chk("w1_din", 64'(bus.imem_din), 64'h401B_6000);
    `ifdef IMEM_LOADER_CKSUM_EN
    send_word(32'h0001_0800);
    `else
    @(posedge clk);
    #1;
    `endif
    chk("basic_done", 64'(done), 64'd1);
    chk("basic_hold_done", 64'(cpu_hold), 64'd1);
    @(posedge clk);
    #1;
    chk("basic_done_fall", 64'(done), 64'd0);
    chk("basic_hold_fall", 64'(cpu_hold), 64'd0);
    chk("basic_err", 64'(err), 64'd0);
    chk("basic_nwrites", 64'(wa.size()), 64'd2);

    foreach (vecs[v]) begin
      wa.delete();
      wd.delete();
      d0 = done_cnt;
      $display("frame vec=%0d addr=%h n=%0d", v, vecs[v].addr, vecs[v].n);
      if (vecs[v].garbage) begin
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        chk("garbage_nowrite", 64'(wa.size()), 64'd0);
        chk("garbage_nohold", 64'(cpu_hold), 64'd0);
      end
      send_hdr(vecs[v].addr, vecs[v].n, vecs[v].gap);
      if (vecs[v].n >= 16'd1) send_word(vecs[v].w0, vecs[v].gap);
      if (vecs[v].n >= 16'd2) send_word(vecs[v].w1, vecs[v].gap);
      `ifdef IMEM_LOADER_CKSUM_EN
      send_word(vecs[v].ck, vecs[v].gap);
      `endif
      wait_done(d0 + 1);
      chk("vec_nwrites", 64'(wa.size()), 64'(vecs[v].n));
      if (wa.size() >= 1 && vecs[v].n >= 16'd1) begin
        chk("vec_a0", 64'(wa[0]), 64'(vecs[v].ea0));
        chk("vec_d0", 64'(wd[0]), 64'(vecs[v].w0));
      end
      if (wa.size() >= 2 && vecs[v].n >= 16'd2) begin
        chk("vec_a1", 64'(wa[1]), 64'(vecs[v].ea1));
        chk("vec_d1", 64'(wd[1]), 64'(vecs[v].w1));
      end
      chk("vec_err", 64'(err), 64'(vecs[v].exp_err));
      chk("vec_hold_idle", 64'(cpu_hold), 64'd0);
    end

    // err stays set through idle time and garbage, clears on the next MAGIC.
    repeat (5) @(negedge clk);
    chk("err_held_idle", 64'(err), 64'(CK));
    send_byte(8'h55);
    chk("err_held_garbage", 64'(err), 64'(CK));
    wa.delete();
    wd.delete();
    d0 = done_cnt;
    $display("frame errclr addr=200 n=1");
    send_byte(8'hB0);
    chk("err_cleared", 64'(err), 64'd0);
    send_word(32'h0000_0200);
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'hCAFE_F00D);
    `ifdef IMEM_LOADER_CKSUM_EN
    send_word(32'hCAFE_F00D);
    `endif
    wait_done(d0 + 1);
    chk("errclr_nwrites", 64'(wa.size()), 64'd1);
    chk("errclr_err", 64'(err), 64'd0);

    // Reset after two data bytes: everything returns to reset values at once.
    $display("frame aborted by reset");
    send_hdr(32'h0000_0020, 16'd1);
    send_byte(8'hDE);
    send_byte(8'hAD);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_hold", 64'(cpu_hold), 64'd0);
    chk("mid_rst_ready", 64'(bus.rx_ready), 64'd1);
    chk("mid_rst_we", 64'(bus.imem_we), 64'd0);
    chk("mid_rst_addr", 64'(bus.imem_addr), 64'd0);
    chk("mid_rst_din", 64'(bus.imem_din), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    wa.delete();
    wd.delete();
    d0 = done_cnt;
    $display("frame after reset addr=20 n=1");
    send_hdr(32'h0000_0020, 16'd1);
    send_word(32'hDEAD_BEEF);
    `ifdef IMEM_LOADER_CKSUM_EN
    send_word(32'hDEAD_BEEF);
    `endif
    wait_done(d0 + 1);
    chk("post_rst_nwrites", 64'(wa.size()), 64'd1);
    if (wa.size() >= 1) begin
      chk("post_rst_addr", 64'(wa[0]), 64'h20);
      chk("post_rst_din", 64'(wd[0]), 64'hDEAD_BEEF);
    end
    chk("post_rst_err", 64'(err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
